// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// UART_RX_PARITY_EN adds the parity state to the FSM encoding.
package uart_pkg;

  localparam int unsigned UART_DEFAULT_PRESCALER = 200;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake plus error pulses between the UART receiver and its consumer.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] O_DATA;
  logic                 O_VALID;
  logic                 I_READY;
  logic                 O_FRAME_ERR;
  logic                 O_OVERRUN;
  logic                 O_PARITY_ERR;

  modport master (
    output O_DATA,
    output O_VALID,
    input  I_READY,
    output O_FRAME_ERR,
    output O_OVERRUN,
    output O_PARITY_ERR
  );

  modport slave (
    input  O_DATA,
    input  O_VALID,
    output I_READY,
    input  O_FRAME_ERR,
    input  O_OVERRUN,
    input  O_PARITY_ERR
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to RESET_VALUE.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style frames into a single-entry holding register with error pulses.
// Define UART_RX_PARITY_EN to receive and check an even parity bit after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALER = UART_DEFAULT_PRESCALER,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      UART_RX,
  uart_rx_if.master rx_bus
);
  localparam int unsigned    CntW     = $clog2(PRESCALER);
  localparam int unsigned    BitW     = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(PRESCALER / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(PRESCALER - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);

  if (PRESCALER < 4) begin : g_bad_prescaler
    $fatal(1, "uart_rx: PRESCALER must be at least 4");
  end

  uart_state_e          state_q, state_d;
  logic                 line_s, line_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_done;
  logic                 expired;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  uart_sync2 #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (UART_RX),
    .q_o   (line_s)
  );

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    frame_done  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // line_q is the previous synchronized sample, so this is a true falling edge
        if (line_q && !line_s) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
          bit_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (!expired) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (!line_s) begin
          state_d = StData;
          cnt_d   = FullLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (!expired) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shreg_d = {line_s, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BitW'(1);
          cnt_d   = FullLoad;
          if (bit_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!expired) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          parity_err_d = (line_s != ^shreg_q);
          par_bad_d    = (line_s != ^shreg_q);
          cnt_d        = FullLoad;
          state_d      = StStop;
        end
      end
`endif
      StStop: begin
        if (!expired) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (line_s) begin
          state_d = StIdle;
`ifdef UART_RX_PARITY_EN
          frame_done = !par_bad_q;
`else
          frame_done = 1'b1;
`endif
        end else begin
          frame_err_d = 1'b1;
          state_d     = StBreak;
        end
      end
      StBreak: begin
        if (line_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Single-entry holding register; a same-cycle transfer frees the slot for the new byte.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && rx_bus.I_READY) valid_d = 1'b0;
    if (frame_done) begin
      if (!valid_q || rx_bus.I_READY) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      line_q      <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_s;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx_bus.O_PARITY_ERR = parity_err_q;
`else
  assign rx_bus.O_PARITY_ERR = 1'b0;
`endif

  assign rx_bus.O_DATA      = data_q;
  assign rx_bus.O_VALID     = valid_q;
  assign rx_bus.O_FRAME_ERR = frame_err_q;
  assign rx_bus.O_OVERRUN   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at PRESCALER=8, DATA_BITS=8; honours UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int unsigned P  = 8;
  localparam int unsigned DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif
  // start edge -> sync (2) -> edge detect (1) -> half bit -> remaining bits up to stop sample
  localparam int unsigned StopEdge = 3 + P / 2 + P * (DB + 1 + ParBits);

  logic CLK     = 1'b0;
  logic RST     = 1'b1;
  logic UART_RX = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cycles = 0;
  int frame_errs = 0;
  int overruns = 0;
  int parity_errs = 0;
  int rise_cyc = 0;
  logic valid_prev;
  logic [7:0] exp_q[$];

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(
    .PRESCALER (P),
    .DATA_BITS (DB)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .UART_RX (UART_RX),
    .rx_bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    UART_RX = b;
    repeat (P) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par,
                            output int t0);
    @(posedge CLK);
    #1;
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < int'(DB); i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par !== par) $display("unused parity argument");
`endif
    drive_bit(stop);
  endtask

  // Output monitor: pulse counters and scoreboard pop on every transfer.
  initial begin
    valid_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (bus.O_VALID && !valid_prev) rise_cyc = cyc;
        if (bus.O_VALID) valid_cycles++;
        if (bus.O_FRAME_ERR) frame_errs++;
        if (bus.O_OVERRUN) overruns++;
        if (bus.O_PARITY_ERR) parity_errs++;
        if (bus.O_VALID && bus.I_READY) begin
          check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check_eq("rx_data", 32'(bus.O_DATA), 32'(exp_q.pop_front()));
        end
      end
      valid_prev = bus.O_VALID;
    end
  end

  initial begin
    int t0;
    int v0;
    int fe0;
    int ov0;
    int pe0;
    bus.I_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    check_eq("rst_valid", 32'(bus.O_VALID), 32'd0);
    check_eq("rst_data", 32'(bus.O_DATA), 32'd0);
    check_eq("rst_frame_err", 32'(bus.O_FRAME_ERR), 32'd0);
    check_eq("rst_overrun", 32'(bus.O_OVERRUN), 32'd0);
    check_eq("rst_parity_err", 32'(bus.O_PARITY_ERR), 32'd0);
    idle(2 * P);

    // 0xA5: data, exact latency, single valid cycle, no error pulses
    v0 = valid_cycles;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5, t0);
    idle(P);
    check_eq("a5_latency", 32'(rise_cyc - t0), 32'(StopEdge));
    check_eq("a5_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check_eq("a5_no_errs", 32'(frame_errs + overruns + parity_errs), 32'd0);

    // Short low glitch is rejected silently
    v0 = valid_cycles;
    @(posedge CLK);
    #1 UART_RX = 1'b0;
    idle(3);
    UART_RX = 1'b1;
    idle(3 * P);
    check_eq("glitch_no_valid", 32'(valid_cycles - v0), 32'd0);
    check_eq("glitch_no_errs", 32'(frame_errs + overruns + parity_errs), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, ^8'h3C, t0);
    idle(P);

    // Framing error then break held low
    v0  = valid_cycles;
    fe0 = frame_errs;
    send_frame(8'h55, 1'b0, ^8'h55, t0);
    idle(40);
    check_eq("brk_frame_err", 32'(frame_errs - fe0), 32'd1);
    check_eq("brk_no_valid", 32'(valid_cycles - v0), 32'd0);
    UART_RX = 1'b1;
    idle(2 * P);
    check_eq("brk_no_valid_after", 32'(valid_cycles - v0), 32'd0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, ^8'h01, t0);
    idle(P);

    // Overrun: consumer stalled, second byte dropped
    bus.I_READY = 1'b0;
    ov0 = overruns;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, ^8'h11, t0);
    idle(P);
    send_frame(8'h22, 1'b1, ^8'h22, t0);
    idle(P);
    check_eq("ovr_data_held", 32'(bus.O_DATA), 32'h11);
    check_eq("ovr_valid_held", 32'(bus.O_VALID), 32'd1);
    check_eq("ovr_pulse", 32'(overruns - ov0), 32'd1);
    bus.I_READY = 1'b1;
    idle(1);
    bus.I_READY = 1'b0;
    idle(P);

    // Transfer on the completion cycle loads the new byte without overrun
    ov0 = overruns;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, ^8'h11, t0);
    idle(P);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1, ^8'h22, t0);
      begin
        @(posedge CLK);
        repeat (StopEdge - 1) @(posedge CLK);
        #1 bus.I_READY = 1'b1;
        @(posedge CLK);
        #1 bus.I_READY = 1'b0;
      end
    join
    check_eq("same_cycle_valid", 32'(bus.O_VALID), 32'd1);
    check_eq("same_cycle_data", 32'(bus.O_DATA), 32'h22);
    check_eq("same_cycle_no_ovr", 32'(overruns - ov0), 32'd0);
    bus.I_READY = 1'b1;
    idle(P);

    // Reset mid-frame after four data bits of 0xFF
    v0 = valid_cycles;
    @(posedge CLK);
    #1;
    drive_bit(1'b0);
    repeat (4) drive_bit(1'b1);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check_eq("midrst_data", 32'(bus.O_DATA), 32'd0);
    check_eq("midrst_valid", 32'(bus.O_VALID), 32'd0);
    idle(8 * P);
    check_eq("midrst_no_valid", 32'(valid_cycles - v0), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, ^8'h81, t0);
    idle(P);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so even parity requires a 1
    v0  = valid_cycles;
    pe0 = parity_errs;
    send_frame(8'h07, 1'b1, 1'b0, t0);
    idle(P);
    check_eq("par_err_pulse", 32'(parity_errs - pe0), 32'd1);
    check_eq("par_err_no_valid", 32'(valid_cycles - v0), 32'd0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, t0);
    idle(P);
    check_eq("par_ok_no_err", 32'(parity_errs - pe0), 32'd1);
`else
    pe0 = parity_errs;
    check_eq("par_tied_low", 32'(pe0), 32'd0);
`endif

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    check_eq("total_frame_errs", 32'(frame_errs), 32'd1);
    check_eq("total_overruns", 32'(overruns), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter PRESCALER, default 200, clock cycles per UART bit (100 MHz / 500 kbaud); legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 UART_RX  input  1  asynchronous serial line; idle high; 1 start bit, DATA_BITS data bits LSB first, optional parity bit, 1 stop bit.
REQ-006 O_DATA  output  DATA_BITS  received byte; valid while O_VALID=1.
REQ-007 O_VALID  output  1  received byte available.
REQ-008 I_READY  input  1  consumer accepts; transfer occurs on a cycle with O_VALID=1 and I_READY=1.
REQ-009 O_FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 O_OVERRUN  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
REQ-011 O_PARITY_ERR  output  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.

Function
REQ-012 UART_RX passes through a 2-flop synchronizer before any use; all timing below counts from the synchronized signal.
REQ-013 FSM states: IDLE, START, DATA, PARITY (exists only with the macro), STOP, BREAK.
REQ-014 IDLE: a high-to-low transition on the synchronized line -> START; bit counter = 0; prescale counter loaded to PRESCALER/2 - 1 (integer division).
REQ-015 START: on prescale expiry, sample; low -> DATA with prescale counter reloaded to PRESCALER-1; high -> IDLE (glitch rejected, no flag raised).
REQ-016 DATA: on each prescale expiry, shift the sample into the MSB of the shift register (LSB-first reception); after DATA_BITS samples -> PARITY if compiled in, else STOP.
REQ-017 STOP: on prescale expiry, sample. High -> frame complete, next state IDLE. Low -> O_FRAME_ERR pulse, byte discarded, next state BREAK.
REQ-018 BREAK: remain until the synchronized line is high, then -> IDLE; no new frame starts while the line is held low.
REQ-019 Completion latency: O_VALID rises in the cycle after the stop-bit sample edge; O_DATA is loaded in that same cycle.
REQ-020 The holding register is single-entry. O_VALID clears on transfer. O_DATA is stable while O_VALID=1 and I_READY=0.
REQ-021 If a frame completes while O_VALID=1 and I_READY=0: new byte dropped, old byte kept, O_OVERRUN pulses.
REQ-022 If a frame completes in the same cycle as a transfer: the new byte is loaded, O_VALID stays 1, and O_OVERRUN does not pulse.
REQ-023 Counter widths: prescale counter is $clog2(PRESCALER) bits; bit counter is $clog2(DATA_BITS+1) bits; no wrap occurs within legal parameter ranges.
REQ-024 A PRESCALER value below 4 is a fatal elaboration error.

Reset
REQ-025 RST=1 for one cycle forces: FSM IDLE; synchronizer flops 1; counters 0; O_DATA 0; O_VALID, O_FRAME_ERR, O_OVERRUN, O_PARITY_ERR 0.
REQ-026 Reset mid-frame discards the partial byte; after RST deasserts, reception restarts only on the next falling edge of the line.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state samples one bit after the data bits and compares it with even parity of the data; mismatch -> O_PARITY_ERR pulses in the cycle after the sample, and the byte is discarded regardless of the stop bit.
REQ-028 Macro UART_RX_PARITY_EN undefined: no PARITY state and frames carry no parity bit.

Structure
REQ-029 Shared package uart_pkg holds the state enum typedef and the constant UART_DEFAULT_PRESCALER = 200.
REQ-030 Sub-module uart_sync2: 2-flop synchronizer with parameterized reset value 1; instantiated once.

Verification (PRESCALER=8, DATA_BITS=8, consumer ready unless stated)
REQ-031 Frame 0xA5 with stop=1 -> O_DATA=0xA5, one O_VALID cycle exactly 1 cycle after the stop sample; no error pulses.
REQ-032 Line low for 3 cycles, then high -> no O_VALID, no error pulse, FSM returns to IDLE; a following frame 0x3C is received correctly.
REQ-033 Frame 0x55 with stop=0, line then held low for 40 cycles -> one O_FRAME_ERR pulse, no O_VALID, no new frame until the line goes high; next frame 0x01 received.
REQ-034 I_READY=0; frames 0x11 then 0x22 -> O_DATA holds 0x11, one O_OVERRUN pulse; with I_READY pulsed exactly on the 0x22 completion cycle -> 0x22 loaded and no overrun.
REQ-035 RST asserted after 4 data bits of 0xFF -> outputs cleared, no O_VALID; the next full frame 0x81 is received correctly.
REQ-036 With UART_RX_PARITY_EN: 0x07 with a parity bit of 0 -> O_PARITY_ERR pulse, no O_VALID; 0x07 with a parity bit of 1 -> O_DATA=0x07.
